// File: rtl/mem_stage_lsu_if.sv
// Bus bundle for the Memory-stage load/store unit: EX/MEM inputs,
// data RAM port and MEM/WB outputs. The LSU takes the slave side.
interface mem_stage_lsu_if #(
   parameter int ADDR_WIDTH = 8
);
   // EX/MEM register side
   logic                  in_valid;
   logic                  in_mem_read;
   logic                  in_mem_write;
   logic [15:0]           in_alu_result;
   logic [15:0]           in_store_data;
   logic [3:0]            in_rd;
   logic                  in_wre;
   // data RAM side
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [15:0]           ram_wdata;
   logic                  ram_we;
   logic                  ram_re;
   logic [15:0]           ram_rdata;
   // MEM/WB register side and pipeline control
   logic                  stall;
   logic                  out_valid;
   logic [15:0]           out_data;
   logic [3:0]            out_rd;
   logic                  out_wre;
   logic                  addr_err;

   modport master (
      output in_valid, in_mem_read, in_mem_write, in_alu_result,
             in_store_data, in_rd, in_wre, ram_rdata,
      input  ram_addr, ram_wdata, ram_we, ram_re,
             stall, out_valid, out_data, out_rd, out_wre, addr_err
   );

   modport slave (
      input  in_valid, in_mem_read, in_mem_write, in_alu_result,
             in_store_data, in_rd, in_wre, ram_rdata,
      output ram_addr, ram_wdata, ram_we, ram_re,
             stall, out_valid, out_data, out_rd, out_wre, addr_err
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Stores are single-cycle RAM writes, loads
// stall the upstream pipeline for READ_LATENCY cycles while a synchronous
// RAM read completes, and non-memory ops pass the ALU result straight on.
module mem_stage_lsu #(
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic           clk,
   input  logic           reset,
   mem_stage_lsu_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_t;

   // READ_LATENCY-1 is at most 3
   localparam int CNT_W = 2;

   state_t           state;
   logic [CNT_W-1:0] lat_cnt;
   logic             addr_err_q;

   logic             is_load;
   logic             is_store;
   logic             out_of_range;
   logic             bad_access;

   logic             stall;
   logic             out_valid;
   logic [15:0]      out_data;
   logic             out_wre;
   logic             ram_we;
   logic             ram_re;

   // A load wins when both read and write are flagged; the store never fires.
   assign is_load      = bus.in_valid && bus.in_mem_read;
   assign is_store     = bus.in_valid && bus.in_mem_write && !bus.in_mem_read;
   assign out_of_range = (bus.in_alu_result >> ADDR_WIDTH) != '0;
   assign bad_access   = bus.in_valid &&
                         ((bus.in_mem_read && bus.in_mem_write) ||
                          ((bus.in_mem_read || bus.in_mem_write) && out_of_range));

   // Address/data/rd are pure wiring; the RAM only acts on the strobes.
   assign bus.ram_addr  = bus.in_alu_result[ADDR_WIDTH-1:0];
   assign bus.ram_wdata = bus.in_store_data;
   assign bus.out_rd    = bus.in_rd;

   assign bus.stall     = stall;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_wre   = out_wre;
   assign bus.ram_we    = ram_we;
   assign bus.ram_re    = ram_re;
   assign bus.addr_err  = addr_err_q;

   // Output decode: zero-latency for IDLE decisions, load data in WAIT;
   // everything held low while reset is asserted.
   always_comb begin
      stall     = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_wre   = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      if (!reset) begin
         if (state == WAIT) begin
            if (lat_cnt == '0) begin
               out_valid = 1'b1;
               out_data  = bus.ram_rdata;
               out_wre   = bus.in_wre;
            end else begin
               stall = 1'b1;
            end
         end else if (bus.in_valid) begin
            if (is_load) begin
               if (out_of_range) begin
                  // Bad load still retires, writing zero to rd.
                  out_valid = 1'b1;
                  out_wre   = bus.in_wre;
               end else begin
                  ram_re = 1'b1;
                  stall  = 1'b1;
               end
            end else if (is_store) begin
               out_valid = 1'b1;
               out_data  = bus.in_alu_result;
               ram_we    = !out_of_range;
            end else begin
               out_valid = 1'b1;
               out_data  = bus.in_alu_result;
               out_wre   = bus.in_wre;
            end
         end
      end
   end

   // Load sequencer and sticky error flag; upstream inputs are frozen
   // while stalled, so the load's rd/wre are still present in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         addr_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bad_access)
                  addr_err_q <= 1'b1;
               if (is_load && !out_of_range) begin
                  state   <= WAIT;
                  lat_cnt <= CNT_W'(READ_LATENCY - 1);
               end
            end
            WAIT: begin
               if (lat_cnt == '0)
                  state <= IDLE;
               else
                  lat_cnt <= lat_cnt - CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: two DUTs (READ_LATENCY 1 and 3) each with a
// behavioural RAM. A per-instruction timeline model sets the expected
// outputs for every cycle; one negedge process compares them.
module tb_mem_stage_lsu;
   localparam int AW = 8;
   localparam int K_IDLE = 0, K_ALU = 1, K_ST = 2, K_LD = 3, K_BOTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [2];
   logic        i_valid [2];
   logic        i_mr    [2];
   logic        i_mw    [2];
   logic [15:0] i_alu   [2];
   logic [15:0] i_sd    [2];
   logic [3:0]  i_rd    [2];
   logic        i_wre   [2];

   logic          o_stall [2];
   logic          o_valid [2];
   logic          o_wre   [2];
   logic          o_err   [2];
   logic          r_we    [2];
   logic          r_re    [2];
   logic [15:0]   o_data  [2];
   logic [15:0]   r_wdata [2];
   logic [3:0]    o_rd    [2];
   logic [AW-1:0] r_addr  [2];

   // expected values for the current cycle of the active instance
   int          act = 0;
   bit          chk_en = 1'b0;
   bit          e_valid, e_wre, e_stall, e_we, e_re, e_err, e_chk_data;
   logic [15:0] e_data;
   int          lit_kind = 0;
   logic [15:0] lit_val = '0;

   // model state
   logic [15:0] mmem [2][256];
   bit          merr [2];

   int tests = 0;
   int fails = 0;
   int stall_run = 0;

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int RL = (g == 0) ? 1 : 3;
      mem_stage_lsu_if #(.ADDR_WIDTH(AW)) bus ();
      logic [15:0] mem  [256];
      logic [15:0] rd_q [RL];
      logic        rd_v [RL];
      logic [15:0] junk;

      assign bus.in_valid      = i_valid[g];
      assign bus.in_mem_read   = i_mr[g];
      assign bus.in_mem_write  = i_mw[g];
      assign bus.in_alu_result = i_alu[g];
      assign bus.in_store_data = i_sd[g];
      assign bus.in_rd         = i_rd[g];
      assign bus.in_wre        = i_wre[g];
      assign bus.ram_rdata     = rd_v[RL-1] ? rd_q[RL-1] : junk;

      assign o_stall[g] = bus.stall;
      assign o_valid[g] = bus.out_valid;
      assign o_wre[g]   = bus.out_wre;
      assign o_err[g]   = bus.addr_err;
      assign r_we[g]    = bus.ram_we;
      assign r_re[g]    = bus.ram_re;
      assign o_data[g]  = bus.out_data;
      assign r_wdata[g] = bus.ram_wdata;
      assign o_rd[g]    = bus.out_rd;
      assign r_addr[g]  = bus.ram_addr;

      // synchronous RAM: data shows up RL cycles after ram_re, junk otherwise
      always @(posedge clk) begin
         junk <= 16'($urandom());
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         rd_q[0] <= mem[bus.ram_addr];
         rd_v[0] <= bus.ram_re;
         for (int s = 1; s < RL; s++) begin
            rd_q[s] <= rd_q[s-1];
            rd_v[s] <= rd_v[s-1];
         end
      end

      mem_stage_lsu #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
         .clk   (clk),
         .reset (rst[g]),
         .bus   (bus)
      );
   end

   // single checker: per-cycle model compare plus optional literal pin
   always @(negedge clk) begin
      int nt, nf;
      nt = 0;
      nf = 0;
      if (chk_en) begin
         nt = 1;
         if (o_valid[act] !== e_valid || o_wre[act] !== e_wre || o_stall[act] !== e_stall ||
             r_we[act] !== e_we || r_re[act] !== e_re || o_err[act] !== e_err ||
             o_rd[act] !== i_rd[act] || r_addr[act] !== i_alu[act][AW-1:0] ||
             r_wdata[act] !== i_sd[act] || (e_chk_data && o_data[act] !== e_data)) begin
            nf = 1;
            $display("FAIL cycle inst%0d t=%0t: got v=%b wre=%b stall=%b we=%b re=%b err=%b data=%h rd=%h addr=%h wd=%h; want v=%b wre=%b stall=%b we=%b re=%b err=%b data=%h(chk %b) rd=%h addr=%h wd=%h",
                     act, $time, o_valid[act], o_wre[act], o_stall[act], r_we[act], r_re[act],
                     o_err[act], o_data[act], o_rd[act], r_addr[act], r_wdata[act],
                     e_valid, e_wre, e_stall, e_we, e_re, e_err, e_data, e_chk_data,
                     i_rd[act], i_alu[act][AW-1:0], i_sd[act]);
         end
         if (lit_kind != 0) begin
            nt = nt + 1;
            case (lit_kind)
               1: if (o_data[act] !== lit_val) begin
                     nf = nf + 1;
                     $display("FAIL lit_data inst%0d: got %h want %h", act, o_data[act], lit_val);
                  end
               2: if (stall_run != int'(lit_val)) begin
                     nf = nf + 1;
                     $display("FAIL lit_stall_run inst%0d: got %0d want %0d", act, stall_run, lit_val);
                  end
               3: if (o_err[act] !== lit_val[0]) begin
                     nf = nf + 1;
                     $display("FAIL lit_addr_err inst%0d: got %b want %b", act, o_err[act], lit_val[0]);
                  end
               default: ;
            endcase
         end
         stall_run <= o_stall[act] ? stall_run + 1 : 0;
      end
      tests <= tests + nt;
      fails <= fails + nf;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      e_valid = 0; e_wre = 0; e_stall = 0; e_we = 0; e_re = 0;
      e_chk_data = 0; e_data = '0;
   endtask

   task automatic set_in(input int k, input bit v, input bit mr, input bit mw,
                         input logic [15:0] a, input logic [15:0] sd,
                         input logic [3:0] rd, input bit wre);
      i_valid[k] = v; i_mr[k] = mr; i_mw[k] = mw;
      i_alu[k] = a; i_sd[k] = sd; i_rd[k] = rd; i_wre[k] = wre;
   endtask

   // One instruction, held for its whole predicted timeline.
   task automatic do_op(input int k, input int kind, input logic [15:0] a,
                        input logic [15:0] sd, input logic [3:0] rd, input bit wre,
                        input int lk, input logic [15:0] lv);
      bit oor;
      int rl;
      oor = (a >> AW) != 0;
      rl  = (k == 0) ? 1 : 3;
      act = k;
      chk_en = 1;
      set_in(k, kind != K_IDLE, kind == K_LD || kind == K_BOTH,
             kind == K_ST || kind == K_BOTH, a, sd, rd, wre);
      clear_exp();
      e_err = merr[k];
      if (kind == K_LD || kind == K_BOTH) begin
         if (!oor) begin
            for (int c = 0; c < rl; c++) begin
               e_stall = 1; e_re = (c == 0);
               tick();
               if (c == 0 && kind == K_BOTH) merr[k] = 1;
               e_err = merr[k];
            end
            clear_exp();
            e_valid = 1; e_wre = wre; e_chk_data = 1; e_data = mmem[k][a[AW-1:0]];
            lit_kind = lk; lit_val = lv;
            tick();
         end else begin
            e_valid = 1; e_wre = wre; e_chk_data = 1; e_data = '0;
            lit_kind = lk; lit_val = lv;
            tick();
            merr[k] = 1;
         end
      end else if (kind == K_ST) begin
         e_valid = 1; e_we = !oor;
         lit_kind = lk; lit_val = lv;
         tick();
         if (oor) merr[k] = 1;
         else     mmem[k][a[AW-1:0]] = sd;
      end else if (kind == K_ALU) begin
         e_valid = 1; e_wre = wre; e_chk_data = 1; e_data = a;
         lit_kind = lk; lit_val = lv;
         tick();
      end else begin
         lit_kind = lk; lit_val = lv;
         tick();
      end
      lit_kind = 0;
   endtask

   // First reset cycle is not compared (the edge has not happened yet).
   task automatic do_reset(input int k, input int n);
      act = k;
      rst[k] = 1;
      set_in(k, 0, 0, 0, '0, '0, '0, 0);
      chk_en = 0;
      lit_kind = 0;
      tick();
      clear_exp();
      e_err = 0; e_chk_data = 1; e_data = '0;
      chk_en = 1;
      for (int c = 1; c < n; c++) tick();
      rst[k] = 0;
      merr[k] = 0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1;
         set_in(k, 0, 0, 0, '0, '0, '0, 0);
         merr[k] = 0;
      end
      clear_exp();
      e_err = 0;

      // ---- READ_LATENCY = 1 ----
      do_reset(0, 2);
      do_op(0, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0000);
      do_op(0, K_ALU,  16'h1234, 16'h0000, 4'd5, 1'b1, 1, 16'h1234);
      do_op(0, K_ST,   16'h0010, 16'hBEEF, 4'd2, 1'b1, 0, 16'h0000);
      do_op(0, K_LD,   16'h0010, 16'h0000, 4'd3, 1'b1, 1, 16'hBEEF);
      do_op(0, K_ST,   16'h00FF, 16'h7E57, 4'd1, 1'b0, 0, 16'h0000);
      do_op(0, K_LD,   16'h00FF, 16'h0000, 4'd9, 1'b1, 1, 16'h7E57);
      do_op(0, K_LD,   16'h0100, 16'h0000, 4'd4, 1'b1, 1, 16'h0000);
      do_op(0, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0001);
      do_op(0, K_ST,   16'h0100, 16'hCAFE, 4'd4, 1'b1, 0, 16'h0000);
      do_op(0, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0001);
      do_op(0, K_LD,   16'h0010, 16'h0000, 4'd3, 1'b1, 1, 16'hBEEF);

      // ---- READ_LATENCY = 3 ----
      do_reset(1, 2);
      do_op(1, K_ST,   16'h0020, 16'h1111, 4'd1, 1'b0, 0, 16'h0000);
      do_op(1, K_ST,   16'h0021, 16'h2222, 4'd1, 1'b0, 0, 16'h0000);
      do_op(1, K_LD,   16'h0020, 16'h0000, 4'd6, 1'b1, 2, 16'd3);
      do_op(1, K_LD,   16'h0021, 16'h0000, 4'd7, 1'b1, 2, 16'd3);
      do_op(1, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0000);
      do_op(1, K_BOTH, 16'h0020, 16'h5555, 4'd8, 1'b1, 1, 16'h1111);
      do_op(1, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0001);

      // reset while a load is waiting on the RAM
      act = 1; chk_en = 1;
      set_in(1, 1, 1, 0, 16'h0021, 16'h0000, 4'd6, 1'b1);
      clear_exp();
      e_err = merr[1]; e_stall = 1; e_re = 1;
      tick();
      e_re = 0;
      tick();
      do_reset(1, 2);
      do_op(1, K_IDLE, 16'h0000, 16'h0000, 4'd0, 1'b0, 3, 16'h0000);
      do_op(1, K_ALU,  16'h00AB, 16'h0000, 4'd7, 1'b1, 1, 16'h00AB);

      // ---- randomized traffic on both ----
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++)
            do_op(k, K_ST, 16'(i), 16'($urandom()), 4'($urandom()), 1'($urandom()), 0, '0);
         for (int n = 0; n < 150; n++) begin
            int r, kind;
            logic [15:0] a;
            r = int'($urandom_range(0, 99));
            kind = (r < 10) ? K_IDLE : (r < 35) ? K_ALU : (r < 60) ? K_ST :
                   (r < 92) ? K_LD : K_BOTH;
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(256, 65535));
            else if (kind == K_ALU)        a = 16'($urandom());
            else                           a = 16'($urandom_range(0, 31));
            do_op(k, kind, a, 16'($urandom()), 4'($urandom()), 1'($urandom()), 0, '0);
         end
      end

      chk_en = 0;
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the Memory stage of the 16-bit pipelined core.
- Sits between the Execute/Memory pipeline register and the Memory/Writeback register.
- Stores: issues single-cycle data RAM writes.
- Loads: sequences synchronous data RAM reads of fixed latency, asserting a stall to freeze upstream stages.
- Non-memory ops: passes the ALU result through to writeback.

Parameters:
- ADDR_WIDTH, 8, data RAM word-address width; legal addresses are 0 .. 2**ADDR_WIDTH-1.
- READ_LATENCY, 1, cycles from ram_re to valid ram_rdata; range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM register holds a live instruction.
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_alu_result  in  16  ALU result; word address for loads/stores.
- in_store_data  in  16  store data (rs2 value).
- in_rd  in  4  destination register.
- in_wre  in  1  register-file write enable from decode.
- ram_addr  out  ADDR_WIDTH  data RAM address.
- ram_wdata  out  16  data RAM write data.
- ram_we  out  1  data RAM write strobe.
- ram_re  out  1  data RAM read strobe.
- ram_rdata  in  16  data RAM read data, valid READ_LATENCY cycles after ram_re.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB receives out_valid=0.
- out_valid  out  1  result to MEM/WB is live this cycle.
- out_data  out  16  writeback data (load data or ALU result).
- out_rd  out  4  destination register.
- out_wre  out  1  register-file write enable.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (sync, high): state IDLE, latency counter 0, addr_err 0. All outputs go to 0 on the next edge and stay 0 while reset is held.
- ram_addr = in_alu_result[ADDR_WIDTH-1:0] and ram_wdata = in_store_data at all times.
- out_rd = in_rd at all times. Inputs are stable while stall=1 because upstream is frozen.
- Range check: access is out of range when in_alu_result[15:ADDR_WIDTH] != 0.
- FSM states: IDLE, WAIT.
- IDLE, in_valid=0: out_valid=0, out_wre=0, stall=0.
- IDLE, valid non-memory op: out_valid=1, out_data=in_alu_result, out_wre=in_wre. Zero latency, combinational pass-through.
- IDLE, valid store, in range: ram_we=1 for this one cycle; out_valid=1, out_wre=0, stall=0.
- IDLE, valid store, out of range: ram_we=0; set addr_err; out_valid=1, out_wre=0.
- IDLE, valid load, in range: ram_re=1; stall=1; out_valid=0; load counter with READ_LATENCY-1; go WAIT.
- IDLE, valid load, out of range: no RAM access; out_valid=1, out_data=0, out_wre=in_wre; set addr_err; no stall.
- WAIT, counter>0: stall=1, out_valid=0, ram_re=0; decrement counter.
- WAIT, counter==0: ram_rdata is valid. out_valid=1, out_data=ram_rdata, out_wre=in_wre, stall=0; go IDLE.
- Load latency: READ_LATENCY extra stall cycles. Result appears in cycle t+READ_LATENCY for a load issued in cycle t.
- Back-to-back loads: the second load issues in the cycle after the first completes; there is no overlap.
- in_mem_read and in_mem_write both 1: treated as a load; ram_we is never asserted; addr_err is set.
- ram_we and ram_re are never high in the same cycle.
- Reset mid-load: WAIT is abandoned; stall drops on the next edge. A late ram_rdata is ignored.
- addr_err clears only on reset.

Test Plan:
- Reset: hold reset 2 cycles during a WAIT → next cycle stall=0, out_valid=0, ram_re=0, addr_err=0.
- ALU pass-through: in_valid=1, alu_result=0x1234, rd=5, wre=1 → same cycle out_valid=1, out_data=0x1234, out_rd=5, out_wre=1, stall=0.
- Store: alu_result=0x0010, store_data=0xBEEF → ram_we=1 for one cycle, ram_addr=0x10, ram_wdata=0xBEEF, out_wre=0, no stall.
- Load, READ_LATENCY=1: RAM[0x10]=0xBEEF, load rd=3 → cycle t: ram_re=1, stall=1, out_valid=0; cycle t+1: out_data=0xBEEF, out_wre=1, stall=0.
- Load, READ_LATENCY=3, back-to-back with a second load → stall high 3 cycles per load. Second ram_re occurs exactly one cycle after the first result; no overlap.
- Out of range, ADDR_WIDTH=8: load at 0x0100 → out_data=0, no ram_re, addr_err=1. A subsequent store at 0x0100 → no ram_we; addr_err remains 1 until reset.
